control_unit_pipelined: RTL

- Pipelined, parametrised successor to the single-cycle decoder.
- Decodes the 4-bit opcode plus immediate flag in the decode (D) stage and registers control bundles into the execute (E) stage.
- Holds the architectural compare flags and resolves B/BEQ/BGE in E.
- Detects load-use hazards, generating stall and flush to the fetch/decode pipeline registers.

---
 rtl/cu_pkg.sv | 62 ++++++
 rtl/control_unit_pipelined_if.sv | 40 ++++
 rtl/cu_decode.sv | 49 ++++
 rtl/control_unit_pipelined.sv | 88 ++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared types for the pipelined control unit: opcodes, ALU/result-source
// encodings and the control bundle carried from D into E.
package cu_pkg;

    localparam int CU_ALU_W = 4;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_AND = 4'b0010,
        OP_ORR = 4'b0011,
        OP_LSL = 4'b0100,
        OP_CMP = 4'b0101,
        OP_SET = 4'b0110,
        OP_LDR = 4'b0111,
        OP_STR = 4'b1000,
        OP_B   = 4'b1001,
        OP_BEQ = 4'b1010,
        OP_BGE = 4'b1011
    } opcode_e;

    localparam logic [CU_ALU_W-1:0] ALU_ADD    = 4'd0;
    localparam logic [CU_ALU_W-1:0] ALU_SUB    = 4'd1;
    localparam logic [CU_ALU_W-1:0] ALU_AND    = 4'd2;
    localparam logic [CU_ALU_W-1:0] ALU_ORR    = 4'd3;
    localparam logic [CU_ALU_W-1:0] ALU_LSL    = 4'd4;
    localparam logic [CU_ALU_W-1:0] ALU_PASS_B = 4'd5;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_B    = 2'd1,
        BR_EQ   = 2'd2,
        BR_GE   = 2'd3
    } br_e;

    // valid marks a recognised opcode; unknown opcodes decode to all zeros
    typedef struct packed {
        logic                valid;
        logic                reg_write;
        logic                mem_write;
        logic [1:0]          result_src;
        logic                alu_src;
        logic [CU_ALU_W-1:0] alu_ctrl;
        logic                is_cmp;
        logic                is_ldr;
        br_e                 br;
    } ctrl_bundle_t;

    // Branch resolution against the architectural {N,Z} flags
    function automatic logic br_taken(input br_e br, input logic n, input logic z);
        case (br)
            BR_B:    br_taken = 1'b1;
            BR_EQ:   br_taken = z;
            BR_GE:   br_taken = ~n;
            default: br_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_pipelined_if.sv
// D-stage request / E-stage control bus between the datapath and the control unit.
interface control_unit_pipelined_if #(
    parameter int OP_W       = 4,
    parameter int ALU_CTRL_W = 4,
    parameter int REG_W      = 4
);
    logic                  d_valid_i;
    logic [OP_W-1:0]       d_op_i;
    logic                  d_imm_i;
    logic [REG_W-1:0]      d_rd_i;
    logic [REG_W-1:0]      d_rs1_i;
    logic [REG_W-1:0]      d_rs2_i;
    logic                  alu_zero_i;
    logic                  alu_neg_i;
    logic                  ex_valid_o;
    logic                  ex_reg_write_o;
    logic                  ex_mem_write_o;
    logic [1:0]            ex_result_src_o;
    logic                  ex_alu_src_o;
    logic [ALU_CTRL_W-1:0] ex_alu_ctrl_o;
    logic [REG_W-1:0]      ex_rd_o;
    logic                  branch_taken_o;
    logic                  flush_o;
    logic                  stall_o;
    logic [1:0]            flags_o;

    // datapath side
    modport master (
        output d_valid_i, d_op_i, d_imm_i, d_rd_i, d_rs1_i, d_rs2_i, alu_zero_i, alu_neg_i,
        input  ex_valid_o, ex_reg_write_o, ex_mem_write_o, ex_result_src_o, ex_alu_src_o,
               ex_alu_ctrl_o, ex_rd_o, branch_taken_o, flush_o, stall_o, flags_o
    );

    // control unit side
    modport slave (
        input  d_valid_i, d_op_i, d_imm_i, d_rd_i, d_rs1_i, d_rs2_i, alu_zero_i, alu_neg_i,
        output ex_valid_o, ex_reg_write_o, ex_mem_write_o, ex_result_src_o, ex_alu_src_o,
               ex_alu_ctrl_o, ex_rd_o, branch_taken_o, flush_o, stall_o, flags_o
    );
endinterface

// File: rtl/cu_decode.sv
// Combinational opcode + immediate flag to control bundle decoder (D stage).
module cu_decode
    import cu_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [OP_W-1:0] i_op,
    input  logic            i_imm,
    output ctrl_bundle_t    o_ctrl
);

    // Table lookup; anything not listed stays an all-zero (invalid) bundle
    always_comb begin
        o_ctrl = '0;
        case (i_op)
            OP_W'(OP_ADD): begin o_ctrl.valid = 1'b1; o_ctrl.reg_write = 1'b1; o_ctrl.alu_ctrl = ALU_ADD; o_ctrl.alu_src = i_imm; end
            OP_W'(OP_SUB): begin o_ctrl.valid = 1'b1; o_ctrl.reg_write = 1'b1; o_ctrl.alu_ctrl = ALU_SUB; o_ctrl.alu_src = i_imm; end
            OP_W'(OP_AND): begin o_ctrl.valid = 1'b1; o_ctrl.reg_write = 1'b1; o_ctrl.alu_ctrl = ALU_AND; o_ctrl.alu_src = i_imm; end
            OP_W'(OP_ORR): begin o_ctrl.valid = 1'b1; o_ctrl.reg_write = 1'b1; o_ctrl.alu_ctrl = ALU_ORR; o_ctrl.alu_src = i_imm; end
            OP_W'(OP_LSL): begin o_ctrl.valid = 1'b1; o_ctrl.reg_write = 1'b1; o_ctrl.alu_ctrl = ALU_LSL; o_ctrl.alu_src = i_imm; end
            OP_W'(OP_CMP): begin
                o_ctrl.valid    = 1'b1;
                o_ctrl.alu_ctrl = ALU_SUB;
                o_ctrl.alu_src  = i_imm;
                o_ctrl.is_cmp   = 1'b1;
            end
            OP_W'(OP_SET): begin o_ctrl.valid = 1'b1; o_ctrl.reg_write = 1'b1; o_ctrl.alu_ctrl = ALU_PASS_B; o_ctrl.alu_src = i_imm; end
            OP_W'(OP_LDR): begin
                o_ctrl.valid      = 1'b1;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.result_src = RES_MEM;
                o_ctrl.alu_ctrl   = ALU_ADD;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.is_ldr     = 1'b1;
            end
            OP_W'(OP_STR): begin
                o_ctrl.valid     = 1'b1;
                o_ctrl.mem_write = 1'b1;
                o_ctrl.alu_ctrl  = ALU_ADD;
                o_ctrl.alu_src   = 1'b1;
            end
            OP_W'(OP_B):   begin o_ctrl.valid = 1'b1; o_ctrl.alu_ctrl = ALU_ADD; o_ctrl.br = BR_B;  end
            OP_W'(OP_BEQ): begin o_ctrl.valid = 1'b1; o_ctrl.alu_ctrl = ALU_ADD; o_ctrl.br = BR_EQ; end
            OP_W'(OP_BGE): begin o_ctrl.valid = 1'b1; o_ctrl.alu_ctrl = ALU_ADD; o_ctrl.br = BR_GE; end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/control_unit_pipelined.sv
// Pipelined control unit: D-stage decode, E-stage control register, {N,Z}
// flags, branch resolution in E and load-use stall generation.
module control_unit_pipelined
    import cu_pkg::*;
#(
    parameter int OP_W       = 4,
    parameter int ALU_CTRL_W = 4,
    parameter int REG_W      = 4,
    parameter int LOAD_LAT   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    control_unit_pipelined_if.slave  bus
);

    // counter only needs to reach LOAD_LAT-1
    localparam int CNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

    ctrl_bundle_t      w_dec;
    ctrl_bundle_t      r_ex;
    logic [REG_W-1:0]  r_ex_rd;
    logic [1:0]        r_flags;        // {N,Z}
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_hazard;
    logic              w_taken;
    logic              w_stall;

    cu_decode #(.OP_W(OP_W)) u_decode (
        .i_op   (bus.d_op_i),
        .i_imm  (bus.d_imm_i),
        .o_ctrl (w_dec)
    );

    // Load-use hazard, branch resolution and overall stall request
    always_comb begin
        w_hazard = r_ex.valid && r_ex.is_ldr && bus.d_valid_i &&
                   ((r_ex_rd == bus.d_rs1_i) || (!bus.d_imm_i && (r_ex_rd == bus.d_rs2_i)));
        w_taken  = r_ex.valid && br_taken(r_ex.br, r_flags[1], r_flags[0]);
        w_stall  = w_hazard || (r_stall_cnt != '0);
    end

    // E register: flush or stall inserts a bubble, otherwise take the D bundle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex    <= '0;
            r_ex_rd <= '0;
        end else if (w_taken || w_stall || !bus.d_valid_i || !w_dec.valid) begin
            r_ex    <= '0;
            r_ex_rd <= '0;
        end else begin
            r_ex    <= w_dec;
            r_ex_rd <= bus.d_rd_i;
        end
    end

    // Flags capture the ALU result of a CMP sitting in E
    always_ff @(posedge clk) begin
        if (rst)
            r_flags <= 2'b00;
        else if (r_ex.valid && r_ex.is_cmp)
            r_flags <= {bus.alu_neg_i, bus.alu_zero_i};
    end

    // Extra stall cycles after a load-use hazard; a redirect cancels them
    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (w_taken)
            r_stall_cnt <= '0;
        else if (w_hazard)
            r_stall_cnt <= CNT_W'(LOAD_LAT - 1);
        else if (r_stall_cnt != '0)
            r_stall_cnt <= r_stall_cnt - CNT_W'(1);
    end

    assign bus.ex_valid_o      = r_ex.valid;
    assign bus.ex_reg_write_o  = r_ex.reg_write;
    assign bus.ex_mem_write_o  = r_ex.mem_write;
    assign bus.ex_result_src_o = r_ex.result_src;
    assign bus.ex_alu_src_o    = r_ex.alu_src;
    assign bus.ex_alu_ctrl_o   = ALU_CTRL_W'(r_ex.alu_ctrl);
    assign bus.ex_rd_o         = r_ex_rd;
    assign bus.branch_taken_o  = w_taken;
    assign bus.flush_o         = w_taken;
    assign bus.stall_o         = w_stall;
    assign bus.flags_o         = r_flags;

endmodule
